// File: rtl/fifo_rr_arbiter.sv
// Round-robin merge of N show-ahead word sources into one registered show-ahead stream.
// Bursts rotate after MAX_BURST words unless the granted source holds with PREEMPT_REQ.
module fifo_rr_arbiter #(
    parameter int N_INPUTS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST_N,
    input  logic                           ENABLE,
    input  logic [N_INPUTS-1:0]            IN_EMPTY,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] IN_DATA,
    input  logic [N_INPUTS-1:0]            IN_PREEMPT_REQ,
    output logic [N_INPUTS-1:0]            IN_READ,
    input  logic                           OUT_READ,
    output logic                           OUT_EMPTY,
    output logic [DATA_WIDTH-1:0]          OUT_DATA,
    output logic [N_INPUTS-1:0]            GRANT,
    output logic [7:0]                     BURST_CNT
);

    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_GRANT
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           gidx_q, gidx_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    oe_q, oe_d;
    logic [DATA_WIDTH-1:0]   od_q, od_d;

    logic                    g_empty;
    logic                    hold;
    logic                    load;
    logic                    any_req;
    logic                    release_g;
    logic [IW-1:0]           pick;
    logic [N_INPUTS-1:0]     g_oh;
    logic [DATA_WIDTH-1:0]   g_data;
    logic [7:0]              cnt_inc;
    int                      idx;

    assign g_empty = IN_EMPTY[gidx_q];
    assign hold    = IN_PREEMPT_REQ[gidx_q];
    assign g_data  = IN_DATA[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign g_oh    = N_INPUTS'(1) << gidx_q;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    assign load = (oe_q | OUT_READ) & (state_q == S_GRANT) & ~g_empty
                & (hold | (cnt_q < MAXB));

    assign IN_READ   = load ? g_oh : '0;
    assign GRANT     = (state_q == S_GRANT) ? g_oh : '0;
    assign OUT_EMPTY = oe_q;
    assign OUT_DATA  = od_q;
    assign BURST_CNT = cnt_q;

    // First non-empty source at or above the rr pointer, wrapping.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_INPUTS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_INPUTS) idx = idx - N_INPUTS;
            if (!any_req && !IN_EMPTY[idx]) begin
                pick    = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        oe_d      = oe_q;
        od_d      = od_q;
        release_g = 1'b0;

        if (load) begin
            od_d  = g_data;
            oe_d  = 1'b0;
            cnt_d = cnt_inc;
        end else if (OUT_READ) begin
            oe_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (ENABLE && any_req) state_d = S_ARB;
            end
            S_ARB: begin
                cnt_d = '0;
                if (ENABLE && any_req) begin
                    gidx_d  = pick;
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // cnt_d already counts a word loaded this cycle
                release_g = ~hold & (g_empty | (cnt_d >= MAXB) | ~ENABLE);
                if (release_g) begin
                    state_d = S_ARB;
                    rr_d    = (gidx_q == IW'(N_INPUTS - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            oe_q    <= 1'b1;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            oe_q    <= oe_d;
            od_q    <= od_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: queue-backed sources, cycle reference model, order scoreboards.
module tb_fifo_rr_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    in_empty;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_pre;
    logic [N-1:0]    in_read;
    logic            ordy;
    logic            out_empty;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    grant;
    logic [7:0]      burst_cnt;

    fifo_rr_arbiter #(
        .N_INPUTS(N),
        .DATA_WIDTH(DW),
        .MAX_BURST(MB)
    ) dut (
        .BUS_CLK(clk),
        .BUS_RST_N(rst_n),
        .ENABLE(en),
        .IN_EMPTY(in_empty),
        .IN_DATA(in_data),
        .IN_PREEMPT_REQ(in_pre),
        .IN_READ(in_read),
        .OUT_READ(ordy),
        .OUT_EMPTY(out_empty),
        .OUT_DATA(out_data),
        .GRANT(grant),
        .BURST_CNT(burst_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] sq[N][$];
    logic [DW-1:0] got[$];
    bit            hide[N];
    bit            pre[N];
    int            rd_pulses;

    // reference model: 0 idle, 1 arbitrating, 2 granted
    int            m_mode, m_g, m_rr, m_cnt;
    bit            m_oe;
    logic [DW-1:0] m_od;

    function automatic logic [DW-1:0] mk(int src, int tid, int seq);
        return {8'(src), 8'(tid), 16'(seq)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_g = 0; m_rr = 0; m_cnt = 0;
        m_oe = 1'b1; m_od = '0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            in_empty[i] = hide[i] || (sq[i].size() == 0);
            in_data[i*DW +: DW] = (sq[i].size() != 0) ? sq[i][0] : '0;
            in_pre[i] = pre[i];
        end
    endtask

    task automatic cyc();
        bit emp[N];
        bit hold, load, any, found;
        logic [N-1:0] e_rd, e_gr;
        int nm, ng, nrr, ncnt;
        bit noe;
        logic [DW-1:0] nod;
        apply();
        @(negedge clk);
        for (int i = 0; i < N; i++) emp[i] = in_empty[i];
        hold = (m_mode == 2) && pre[m_g];
        load = (m_mode == 2) && (m_oe || ordy) && !emp[m_g] && (hold || m_cnt < MB);
        e_rd = load ? N'(1) << m_g : '0;
        e_gr = (m_mode == 2) ? N'(1) << m_g : '0;
        n_tests++;
        if (in_read !== e_rd) begin
            n_fail++;
            $display("FAIL in_read t=%0t got %b expected %b", $time, in_read, e_rd);
        end
        n_tests++;
        if (grant !== e_gr) begin
            n_fail++;
            $display("FAIL grant t=%0t got %b expected %b", $time, grant, e_gr);
        end
        n_tests++;
        if (burst_cnt !== 8'(m_cnt)) begin
            n_fail++;
            $display("FAIL burst_cnt t=%0t got %0d expected %0d", $time, burst_cnt, m_cnt);
        end
        n_tests++;
        if (out_empty !== m_oe) begin
            n_fail++;
            $display("FAIL out_empty t=%0t got %b expected %b", $time, out_empty, m_oe);
        end
        if (!m_oe) begin
            n_tests++;
            if (out_data !== m_od) begin
                n_fail++;
                $display("FAIL out_data t=%0t got %h expected %h", $time, out_data, m_od);
            end
        end
        if (in_read != '0) rd_pulses++;
        if (ordy && !out_empty) got.push_back(out_data);

        nm = m_mode; ng = m_g; nrr = m_rr; ncnt = m_cnt;
        noe = m_oe; nod = m_od;
        if (load) begin
            nod = sq[m_g].pop_front();
            noe = 1'b0;
            ncnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else if (ordy) begin
            noe = 1'b1;
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) if (!emp[i]) any = 1'b1;
        if (m_mode == 0) begin
            if (en && any) nm = 1;
        end else if (m_mode == 1) begin
            ncnt = 0;
            nm = 0;
            if (en && any) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_rr + k) % N;
                    if (!found && !emp[j]) begin
                        ng = j; found = 1'b1;
                    end
                end
                nm = 2;
            end
        end else begin
            if (!hold && (emp[m_g] || ncnt >= MB || !en)) begin
                nm = 1;
                nrr = (m_g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        m_mode = nm; m_g = ng; m_rr = nrr; m_cnt = ncnt;
        m_oe = noe; m_od = nod;
    endtask

    task automatic run_until_idle(int max_cyc);
        int c;
        c = 0;
        while (!(sq[0].size() == 0 && sq[1].size() == 0 && m_oe && m_mode == 0)
               && c < max_cyc) begin
            cyc();
            c++;
        end
        n_tests++;
        if (c >= max_cyc) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d cycles expected < %0d", c, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; ordy = 1'b1;
        for (int i = 0; i < N; i++) begin hide[i] = 0; pre[i] = 0; end
        apply();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({out_empty, out_data, grant, burst_cnt, in_read} !==
            {1'b1, 32'h0, 2'b00, 8'h00, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_state got oe=%b d=%h g=%b c=%0d r=%b expected 1/0/0/0/0",
                     out_empty, out_data, grant, burst_cnt, in_read);
        end
        rst_n = 1'b1;
        model_reset();
        repeat (2) cyc();
    endtask

    task automatic test_two_bursts();
        logic [DW-1:0] exp[$];
        int seq[N];
        int chunk[6] = '{16, 16, 16, 16, 8, 8};
        got.delete();
        for (int w = 0; w < 40; w++) begin
            sq[0].push_back(mk(0, 2, w));
            sq[1].push_back(mk(1, 2, w));
        end
        seq = '{0, 0};
        for (int c = 0; c < 6; c++)
            for (int w = 0; w < chunk[c]; w++) begin
                exp.push_back(mk(c % 2, 2, seq[c % 2]));
                seq[c % 2]++;
            end
        ordy = 1'b1;
        run_until_idle(300);
        n_tests++;
        if (got.size() != 80) begin
            n_fail++;
            $display("FAIL two_count got %0d expected 80", got.size());
        end else begin
            for (int k = 0; k < 80; k++) begin
                n_tests++;
                if (got[k] !== exp[k]) begin
                    n_fail++;
                    $display("FAIL two_order[%0d] got %h expected %h", k, got[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_single();
        got.delete();
        for (int w = 0; w < 5; w++) sq[0].push_back(mk(0, 1, w));
        cyc();
        cyc();
        n_tests++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant got %b expected 01", grant);
        end
        run_until_idle(50);
        n_tests++;
        if (got.size() != 5) begin
            n_fail++;
            $display("FAIL single_count got %0d expected 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_tests++;
                if (got[k] !== mk(0, 1, k)) begin
                    n_fail++;
                    $display("FAIL single_order[%0d] got %h expected %h", k, got[k], mk(0, 1, k));
                end
            end
        end
    endtask

    task automatic test_preempt();
        got.delete();
        pre[1] = 1'b1;
        for (int w = 0; w < 3; w++) sq[1].push_back(mk(1, 3, w));
        for (int w = 0; w < 20; w++) sq[0].push_back(mk(0, 3, w));
        for (int c = 0; c < 15; c++) begin
            cyc();
            if (c >= 1) begin
                n_tests++;
                if (grant !== 2'b10) begin
                    n_fail++;
                    $display("FAIL preempt_hold c=%0d got %b expected 10", c, grant);
                end
            end
        end
        for (int w = 3; w < 6; w++) sq[1].push_back(mk(1, 3, w));
        repeat (6) cyc();
        pre[1] = 1'b0;
        run_until_idle(100);
        n_tests++;
        if (got.size() != 26) begin
            n_fail++;
            $display("FAIL preempt_count got %0d expected 26", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (got[k] !== mk(1, 3, k)) begin
                    n_fail++;
                    $display("FAIL preempt_order[%0d] got %h expected %h", k, got[k], mk(1, 3, k));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        got.delete();
        for (int w = 0; w < 4; w++) sq[0].push_back(mk(0, 4, w));
        ordy = 1'b0;
        rd_pulses = 0;
        repeat (4) cyc();
        held = out_data;
        repeat (16) cyc();
        n_tests++;
        if (rd_pulses != 1) begin
            n_fail++;
            $display("FAIL bp_reads got %0d expected 1", rd_pulses);
        end
        n_tests++;
        if (out_data !== mk(0, 4, 0) || held !== mk(0, 4, 0)) begin
            n_fail++;
            $display("FAIL bp_stable got %h/%h expected %h", held, out_data, mk(0, 4, 0));
        end
        ordy = 1'b1;
        run_until_idle(50);
        n_tests++;
        if (got.size() != 4 || got[3] !== mk(0, 4, 3)) begin
            n_fail++;
            $display("FAIL bp_drain got %0d words expected 4", got.size());
        end
    endtask

    task automatic test_enable_drop();
        int c;
        got.delete();
        for (int w = 0; w < 20; w++) sq[0].push_back(mk(0, 5, w));
        c = 0;
        while (!(m_mode == 2 && m_cnt == 7) && c < 40) begin
            cyc();
            c++;
        end
        ordy = 1'b0;
        en = 1'b0;
        cyc();
        ordy = 1'b1;
        rd_pulses = 0;
        repeat (10) cyc();
        n_tests++;
        if (rd_pulses != 0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL en_idle got reads=%0d grant=%b expected 0/00", rd_pulses, grant);
        end
        n_tests++;
        if (got.size() != 7 || out_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drain got %0d words oe=%b expected 7/1", got.size(), out_empty);
        end
        en = 1'b1;
        run_until_idle(100);
        n_tests++;
        if (got.size() != 20) begin
            n_fail++;
            $display("FAIL en_total got %0d expected 20", got.size());
        end
    endtask

    task automatic test_reset_mid();
        got.delete();
        for (int w = 0; w < 30; w++) begin
            sq[0].push_back(mk(0, 6, w));
            sq[1].push_back(mk(1, 6, w));
        end
        sq[0].pop_front();
        repeat (20) cyc();
        ordy = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_empty, grant, burst_cnt, in_read} !== {1'b1, 2'b00, 8'h00, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid got oe=%b g=%b c=%0d r=%b expected 1/00/0/00",
                     out_empty, grant, burst_cnt, in_read);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy = 1'b1;
        got.delete();
        run_until_idle(300);
        n_tests++;
        if (got.size() == 0 || got[0][31:24] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_resume got first=%h expected src 0", got.size() ? got[0] : '0);
        end
    endtask

    task automatic test_random();
        int seq[N];
        int nxt[N];
        got.delete();
        seq = '{0, 0};
        nxt = '{0, 0};
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(2) == 0) begin
                    sq[i].push_back(mk(i, 7, seq[i]));
                    seq[i]++;
                end
                hide[i] = ($urandom_range(4) == 0);
                if ($urandom_range(19) == 0) pre[i] = !pre[i];
            end
            ordy = ($urandom_range(3) != 0);
            en = ($urandom_range(15) != 0);
            cyc();
        end
        for (int i = 0; i < N; i++) begin hide[i] = 0; pre[i] = 0; end
        en = 1'b1;
        ordy = 1'b1;
        run_until_idle(3000);
        foreach (got[k]) begin
            int s;
            s = int'(got[k][31:24]);
            n_tests++;
            if (s >= N || got[k][15:0] !== 16'(nxt[s])) begin
                n_fail++;
                $display("FAIL rand_order[%0d] got %h expected seq %0d", k, got[k], nxt[s % N]);
            end
            if (s < N) nxt[s]++;
        end
        n_tests++;
        if (nxt[0] != seq[0] || nxt[1] != seq[1]) begin
            n_fail++;
            $display("FAIL rand_count got %0d/%0d expected %0d/%0d", nxt[0], nxt[1], seq[0], seq[1]);
        end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_single();
        test_preempt();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
